dda_step10: RTL and testbench
=============================

DDA_STEP10 -- requirements
Module: dda_step10

Interface
REQ-001 SHALL have no parameters; all data paths are fixed at 10 bits to match the 10-bit divider stage it consumes.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-005 x0  in  10  start value, unsigned; sampled with start.
REQ-006 x1  in  10  end value, unsigned; sampled with start.
REQ-007 count  in  10  number of steps N; sampled with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 div_start  out  1  one-cycle start pulse to the divider.
REQ-010 div_dividend  out  10  |x1-x0|, held stable from issue until the run ends.
REQ-011 div_divider  out  10  N, held stable from issue until the run ends.
REQ-012 div_ready  in  1  divider idle/result-valid flag.
REQ-013 div_quotient  in  10  q = |x1-x0| / N.
REQ-014 div_remainder  in  10  r = |x1-x0| mod N.
REQ-015 out_valid  out  1  out_x is valid.
REQ-016 out_ready  in  1  downstream accepts; transfer when out_valid and out_ready are both high.
REQ-017 out_x  out  10  interpolated value.
REQ-018 out_last  out  1  marks the final value (x1) of a run.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, WAIT and STEP.
REQ-020 IDLE with start=1 and N!=0 SHALL register inputs, set dir=(x1<x0), and go to ISSUE.
REQ-021 IDLE with start=1 and N=0 SHALL load q=0, r=0 and go directly to STEP, emitting the single value x0 with out_last=1.
REQ-022 ISSUE SHALL assert div_start for exactly one cycle and go to WAIT.
REQ-023 WAIT SHALL sample div_ready from its first cycle; on div_ready=1 it SHALL capture q and r, clear err, set x=x0 and i=0, and go to STEP.
REQ-024 STEP SHALL drive out_valid=1, out_x=x and out_last=(i==N).
- On a transfer with i<N: x += q, or x -= q when dir=1; err += r; i += 1.
- If the new err >= N: err -= N and x steps one more unit toward x1 in the same cycle.
REQ-025 On a transfer with out_last=1 the FSM SHALL return to IDLE; the next start is accepted in the following cycle.
REQ-026 While out_ready=0, out_x, out_last and all internal state SHALL hold.
REQ-027 start SHALL be ignored when not in IDLE.
REQ-028 Width rules:
- err is 11 bits (err+r <= 2046).
- x is 10 bits and never wraps; the final value equals x1 exactly.
- i is 10 bits.
REQ-029 Latency: with a 10-cycle divider and out_ready held at 1, the first out_valid SHALL occur 13 cycles after the start cycle.
- Throughput is one value per cycle; a run produces N+1 values.

Reset
REQ-030 rst_n low SHALL force IDLE immediately, including mid-run.
- busy, div_start, out_valid and out_last SHALL be 0.
- out_x, err, i, q, r and the div_* data outputs SHALL be 0.
REQ-031 A run interrupted by reset SHALL NOT resume, and no out_valid SHALL be produced until a new start.

Structure
REQ-032 The shared package SHALL hold the FSM state enum and the data-width constant (10).
REQ-033 There SHALL be no sub-module; the divider is instantiated beside this block by the parent and connected through the div_* ports.

Verification
REQ-034 x0=0, x1=10, N=4, out_ready=1 -> out_x 0,2,5,7,10; out_last only on 10; first out_valid 13 cycles after start.
REQ-035 x0=10, x1=0, N=4 -> out_x 10,8,5,3,0; busy drops the cycle after the last transfer.
REQ-036 x0=7, x1=7, N=0 -> single output 7 with out_last=1; div_start never asserted.
REQ-037 x0=0, x1=1023, N=1 with out_ready toggling 0/1 each cycle -> out_x 0,1023 with no duplicates or drops; out_x holds while out_ready=0.
REQ-038 start pulsed while busy, then rst_n asserted mid-STEP -> the busy start is ignored; after reset outputs are 0 and idle; a new run x0=3, x1=9, N=3 yields 3,5,7,9.

Source files
------------

// File: rtl/dda_step10_pkg.sv
// Shared definitions for the dda_step10 interpolator.
//   DDA_W   : data-path width (matches the 10-bit divider stage)
//   state_t : FSM state encoding
package dda_step10_pkg;

    localparam int unsigned DDA_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        STEP
    } state_t;

endpackage

// File: rtl/dda_step10_if.sv
// Handshake/bus bundle for dda_step10.
//   start/x0/x1/count                : run request and its operands
//   busy                             : block is not idle
//   div_start/div_dividend/div_divider : request to the external divider
//   div_ready/div_quotient/div_remainder : divider result
//   out_valid/out_ready/out_x/out_last : interpolated value stream
// The "slave" modport is the dda_step10 side; "master" is the side that
// drives requests, provides the divider result and consumes the stream.
interface dda_step10_if;
    import dda_step10_pkg::*;

    logic             start;
    logic [DDA_W-1:0] x0;
    logic [DDA_W-1:0] x1;
    logic [DDA_W-1:0] count;
    logic             busy;
    logic             div_start;
    logic [DDA_W-1:0] div_dividend;
    logic [DDA_W-1:0] div_divider;
    logic             div_ready;
    logic [DDA_W-1:0] div_quotient;
    logic [DDA_W-1:0] div_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [DDA_W-1:0] out_x;
    logic             out_last;

    modport slave (
        input  start, x0, x1, count, div_ready, div_quotient, div_remainder, out_ready,
        output busy, div_start, div_dividend, div_divider, out_valid, out_x, out_last
    );

    modport master (
        output start, x0, x1, count, div_ready, div_quotient, div_remainder, out_ready,
        input  busy, div_start, div_dividend, div_divider, out_valid, out_x, out_last
    );
endinterface

// File: rtl/dda_step10.sv
// dda_step10: DDA line interpolator producing N+1 values from x0 to x1.
// |x1-x0| / N is computed by an external divider reached through the div_*
// signals; each STEP transfer then advances x by q plus a Bresenham-style
// carry from the accumulated remainder, so the final value lands on x1.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dda_step10_if.slave (request, divider and output stream signals)
module dda_step10
    import dda_step10_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    dda_step10_if.slave  bus
);

    state_t           state;
    logic             busy_r;
    logic             div_start_r;
    logic [DDA_W-1:0] dividend_r;
    logic [DDA_W-1:0] divider_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic             dir;
    logic [DDA_W-1:0] x0_r;
    logic [DDA_W-1:0] n_r;
    logic [DDA_W-1:0] q_r;
    logic [DDA_W-1:0] r_r;
    logic [DDA_W:0]   err;
    logic [DDA_W-1:0] i;
    logic [DDA_W-1:0] x;

    logic [DDA_W:0]   err_sum;
    logic             bump;
    logic [DDA_W:0]   err_nxt;
    logic [DDA_W-1:0] delta;
    logic [DDA_W-1:0] x_nxt;
    logic [DDA_W-1:0] i_nxt;
    logic             xfer;

    assign bus.busy         = busy_r;
    assign bus.div_start    = div_start_r;
    assign bus.div_dividend = dividend_r;
    assign bus.div_divider  = divider_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_last     = out_last_r;
    assign bus.out_x        = x;

    assign xfer = out_valid_r && bus.out_ready;

    // Next step: the remainder carry adds one extra unit whenever err wraps
    // past N. q+bump never exceeds 1023 because r=0 whenever q=1023.
    always_comb begin
        err_sum = err + {1'b0, r_r};
        bump    = (err_sum >= {1'b0, n_r});
        err_nxt = bump ? (err_sum - {1'b0, n_r}) : err_sum;
        delta   = q_r + {{(DDA_W-1){1'b0}}, bump};
        x_nxt   = dir ? (x - delta) : (x + delta);
        i_nxt   = i + {{(DDA_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            div_start_r <= 1'b0;
            dividend_r  <= '0;
            divider_r   <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            dir         <= 1'b0;
            x0_r        <= '0;
            n_r         <= '0;
            q_r         <= '0;
            r_r         <= '0;
            err         <= '0;
            i           <= '0;
            x           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        x0_r   <= bus.x0;
                        n_r    <= bus.count;
                        dir    <= (bus.x1 < bus.x0);
                        if (bus.count == '0) begin
                            q_r         <= '0;
                            r_r         <= '0;
                            err         <= '0;
                            i           <= '0;
                            x           <= bus.x0;
                            out_valid_r <= 1'b1;
                            out_last_r  <= 1'b1;
                            state       <= STEP;
                        end else begin
                            dividend_r  <= (bus.x1 < bus.x0) ? (bus.x0 - bus.x1)
                                                             : (bus.x1 - bus.x0);
                            divider_r   <= bus.count;
                            div_start_r <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_start_r <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (bus.div_ready) begin
                        q_r         <= bus.div_quotient;
                        r_r         <= bus.div_remainder;
                        err         <= '0;
                        x           <= x0_r;
                        i           <= '0;
                        out_valid_r <= 1'b1;
                        out_last_r  <= 1'b0;
                        state       <= STEP;
                    end
                end
                STEP: begin
                    if (xfer) begin
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            x          <= x_nxt;
                            err        <= err_nxt;
                            i          <= i_nxt;
                            out_last_r <= (i_nxt == n_r);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dda_step10.sv
// Testbench for dda_step10 with a behavioural 10-cycle divider.
module tb_dda_step10;
    import dda_step10_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dda_step10_if bus();

    dda_step10 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Divider model: ready drops the cycle after div_start and the result is
    // valid 10 cycles later.
    int unsigned div_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.div_ready     <= 1'b1;
            bus.div_quotient  <= '0;
            bus.div_remainder <= '0;
            div_cnt           <= 0;
        end else if (bus.div_start) begin
            bus.div_ready     <= 1'b0;
            div_cnt           <= 9;
            bus.div_quotient  <= (bus.div_divider == 0) ? '0 : bus.div_dividend / bus.div_divider;
            bus.div_remainder <= (bus.div_divider == 0) ? '0 : bus.div_dividend % bus.div_divider;
        end else if (!bus.div_ready) begin
            if (div_cnt == 0) bus.div_ready <= 1'b1;
            else div_cnt <= div_cnt - 1;
        end
    end

    typedef struct {
        logic [9:0] x;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [9:0] x0;
        logic [9:0] x1;
        logic [9:0] n;
        int         mode;   // 0: ready=1, 1: toggle, 2: random
        bit         lat;    // check 13-cycle first-output latency
    } vec_t;
    vec_t tbl[9];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input logic [9:0] a, input logic [9:0] b, input logic [9:0] n,
                           input int mode, input bit lat, input int abort_at);
        int unsigned d;
        int unsigned off;
        int cyc;
        int budget;
        int pulses;
        int popped;
        bit done;
        bit first_seen;
        bit prev_stall;
        logic [9:0] prev_x;
        logic prev_last;
        logic rdy;
        exp_t e;
        d = (b >= a) ? int'(b - a) : int'(a - b);
        for (int k = 0; k <= int'(n); k++) begin
            off = (n == 0) ? 0 : (k * d) / n;
            e.x    = (b >= a) ? 10'(a + off) : 10'(a - off);
            e.last = (k == int'(n));
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b1; bus.x0 = a; bus.x1 = b; bus.count = n;
        cyc = 0; budget = 40 + 8 * (int'(n) + 1); pulses = 0; popped = 0;
        done = 0; first_seen = 0; prev_stall = 0; prev_x = '0; prev_last = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (cyc == 3 && n != 0) begin
                bus.start = 1'b1; bus.x0 = 10'd1000; bus.x1 = 10'd1; bus.count = 10'd2;
            end
            if (bus.div_start) begin
                pulses++;
                chk("div_dividend", int'(bus.div_dividend), int'(d));
                chk("div_divider", int'(bus.div_divider), int'(n));
            end
            if (prev_stall) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_x", int'(bus.out_x), int'(prev_x));
                chk("hold_last", int'(bus.out_last), int'(prev_last));
            end
            if (bus.out_valid && !first_seen) begin
                first_seen = 1;
                if (lat) chk("latency", cyc, 13);
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 2) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output", 1, 0);
                    done = 1;
                end else begin
                    e = exp_q.pop_front();
                    chk("out_x", int'(bus.out_x), int'(e.x));
                    chk("out_last", int'(bus.out_last), int'(e.last));
                    popped++;
                    if (e.last || popped == abort_at) done = 1;
                end
            end
            prev_stall = bus.out_valid && !rdy;
            prev_x     = bus.out_x;
            prev_last  = bus.out_last;
        end
        if (!done) chk("timeout", 1, 0);
        if (abort_at < 0) begin
            chk("div_start_pulses", pulses, (n != 0) ? 1 : 0);
            chk("queue_empty", exp_q.size(), 0);
            @(negedge clk);
            chk("busy_after_last", int'(bus.busy), 0);
            chk("valid_after_last", int'(bus.out_valid), 0);
        end
    endtask

    initial begin
        int bad;
        tbl[0] = '{10'd0,    10'd10,   10'd4,    0, 1'b1};
        tbl[1] = '{10'd10,   10'd0,    10'd4,    0, 1'b1};
        tbl[2] = '{10'd7,    10'd7,    10'd0,    0, 1'b0};
        tbl[3] = '{10'd0,    10'd1023, 10'd1,    1, 1'b0};
        tbl[4] = '{10'd1023, 10'd0,    10'd7,    2, 1'b0};
        tbl[5] = '{10'd100,  10'd357,  10'd17,   2, 1'b0};
        tbl[6] = '{10'd500,  10'd499,  10'd9,    0, 1'b1};
        tbl[7] = '{10'd5,    10'd900,  10'd1023, 0, 1'b0};
        tbl[8] = '{10'd0,    10'd0,    10'd3,    1, 1'b0};

        bus.start = 1'b0; bus.x0 = '0; bus.x1 = '0; bus.count = '0; bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_x", int'(bus.out_x), 0);
        chk("rst_div_start", int'(bus.div_start), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++)
            run_vec(tbl[v].x0, tbl[v].x1, tbl[v].n, tbl[v].mode, tbl[v].lat, -1);

        // Mid-run abort: start while busy is ignored, reset clears everything.
        run_vec(10'd0, 10'd100, 10'd20, 0, 1'b0, 5);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start = 1'b1; bus.x0 = 10'd1; bus.x1 = 10'd2; bus.count = 10'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_start_ignored", int'(bus.busy), 1);
        chk("stall_x", int'(bus.out_x), 25);
        chk("stall_valid", int'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_last", int'(bus.out_last), 0);
        chk("mid_rst_x", int'(bus.out_x), 0);
        chk("mid_rst_div_start", int'(bus.div_start), 0);
        chk("mid_rst_dividend", int'(bus.div_dividend), 0);
        chk("mid_rst_divider", int'(bus.div_divider), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) bad++;
        end
        chk("no_resume", bad, 0);

        run_vec(10'd3, 10'd9, 10'd3, 0, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
